// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: shared types and constants for the memory/IO responder.
// State encoding, IO region tag and error read data.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [2:0]  IO_REGION = 3'b111;
  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mio_wait_cnt.sv
// mio_wait_cnt: loadable down-counter (RAM wait states) that doubles
// as a saturating up-counter (IO timeout).
import mio_bus_pkg::*;

module mio_wait_cnt #(
  parameter int W   = 7,
  parameter int MAX = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // load wins; down stops at zero, up stops at MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end else if (inc && count != MAX_V) begin
      count <= count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mio_bus.sv
// mio_bus: CPU bus responder decoding accesses to block RAM or IO.
// Optional err_addr error log enabled by defining MIO_ERR_LOG_EN.
import mio_bus_pkg::*;

module mio_bus #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 1,
  parameter int IO_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic              bus_err,
`ifdef MIO_ERR_LOG_EN
  output logic [31:0]       err_addr,
`endif
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [27:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic              io_rd,
  output logic              io_we,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready
);

  localparam int CMAX = max2(WAIT_STATES, IO_TIMEOUT);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] WS_V  = CW'(WAIT_STATES);
  localparam logic [CW-1:0] TO_V  = CW'(IO_TIMEOUT - 1);

  state_t state_q, state_d;

  logic              wr_q, wr_d;
  logic [31:0]       data_d;
  logic              ready_d;
  logic              err_d;
  logic              err_hit;
  logic [RAM_AW-1:0] ram_addr_d;
  logic              ram_we_d;
  logic [31:0]       ram_din_d;
  logic [27:0]       io_addr_d;
  logic [31:0]       io_wdata_d;
  logic              io_rd_d;
  logic              io_we_d;

  logic              cnt_load;
  logic [CW-1:0]     cnt_val;
  logic              cnt_dec;
  logic              cnt_inc;
  logic [CW-1:0]     cnt;
  logic              cnt_zero;

  logic req;
  logic wr;
  logic is_io;
  logic io_fetch;
  logic io_data;

  assign req      = MemRead | MemWrite;
  assign wr       = MemWrite;
  assign is_io    = (Addr_in[31:29] == IO_REGION);
  assign io_fetch = is_io & CPU_MIO;
  assign io_data  = is_io & ~CPU_MIO;

  mio_wait_cnt #(
    .W   (CW),
    .MAX (IO_TIMEOUT)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // next-state and next-output decode; every output is registered
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    data_d     = Data_out;
    ready_d    = 1'b0;
    err_d      = bus_err;
    err_hit    = 1'b0;
    ram_addr_d = ram_addr;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din;
    io_addr_d  = io_addr;
    io_wdata_d = io_wdata;
    io_rd_d    = 1'b0;
    io_we_d    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d = wr;
          unique case (1'b1)
            io_fetch: begin
              ready_d = 1'b1;
              err_d   = 1'b1;
              err_hit = 1'b1;
              state_d = RESP;
            end
            io_data: begin
              io_addr_d  = Addr_in[27:0];
              io_wdata_d = Data_in;
              io_rd_d    = ~wr;
              io_we_d    = wr;
              cnt_load   = 1'b1;
              state_d    = IO_WAIT;
            end
            default: begin
              ram_addr_d = Addr_in[RAM_AW+1:2];
              ram_din_d  = Data_in;
              ram_we_d   = wr;
              cnt_load   = 1'b1;
              cnt_val    = WS_V;
              state_d    = RAM_WAIT;
            end
          endcase
        end
      end
      RAM_WAIT: begin
        if (cnt_zero) begin
          if (!wr_q) data_d = ram_dout;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IO_WAIT: begin
        if (io_ready) begin
          if (!wr_q) data_d = io_rdata;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (cnt == TO_V) begin
          if (!wr_q) data_d = ERR_DATA;
          err_d   = 1'b1;
          err_hit = 1'b1;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          io_rd_d = ~wr_q;
          io_we_d = wr_q;
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      Data_out  <= '0;
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_rd     <= 1'b0;
      io_we     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      Data_out  <= data_d;
      MIO_ready <= ready_d;
      bus_err   <= err_d;
      ram_addr  <= ram_addr_d;
      ram_we    <= ram_we_d;
      ram_din   <= ram_din_d;
      io_addr   <= io_addr_d;
      io_wdata  <= io_wdata_d;
      io_rd     <= io_rd_d;
      io_we     <= io_we_d;
    end
  end

`ifdef MIO_ERR_LOG_EN
  logic [31:0] addr_q;

  // full address of the access in flight, for the error log
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (state_q == IDLE && req) begin
      addr_q <= Addr_in;
    end
  end

  // only the first error after reset is logged
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr <= '0;
    end else if (err_hit && !bus_err) begin
      err_addr <= (state_q == IDLE) ? Addr_in : addr_q;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{Addr_in[28], err_hit};
`endif

endmodule
